// File: rtl/write_back_pkg.sv
// Shared types and sizes for the write-back stage and its register file.
package write_back_pkg;

  localparam int unsigned REG_CNT = 8;
  localparam int unsigned REG_AW  = 3;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/write_back_if.sv
// Bus between the pipeline (read/execute stages, data memory) and the
// write-back stage. master = pipeline side, slave = write_back.
interface write_back_if
  import write_back_pkg::*;
#(
  parameter int D_SIZE = 32
);
  logic [REG_AW-1:0] raddr_1;
  logic [REG_AW-1:0] raddr_2;
  logic [D_SIZE-1:0] rdata_1;
  logic [D_SIZE-1:0] rdata_2;
  logic              ex_valid;
  logic              ex_is_load;
  logic [REG_AW-1:0] ex_dest;
  logic [D_SIZE-1:0] ex_result;
  logic              mem_rvalid;
  logic [D_SIZE-1:0] mem_rdata;
  logic              stall;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_addr;

  modport master (
    output raddr_1, raddr_2, ex_valid, ex_is_load, ex_dest, ex_result,
           mem_rvalid, mem_rdata,
    input  rdata_1, rdata_2, stall, wb_valid, wb_addr
  );

  modport slave (
    input  raddr_1, raddr_2, ex_valid, ex_is_load, ex_dest, ex_result,
           mem_rvalid, mem_rdata,
    output rdata_1, rdata_2, stall, wb_valid, wb_addr
  );
endinterface

// File: rtl/write_back_regfile_array.sv
// 8 x D_SIZE architectural register file: two combinational read ports,
// one synchronous write port, synchronous clear on reset. No hardwired zero.
module regfile_array
  import write_back_pkg::*;
#(
  parameter int D_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [D_SIZE-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_1,
  input  logic [REG_AW-1:0] raddr_2,
  output logic [D_SIZE-1:0] rdata_1,
  output logic [D_SIZE-1:0] rdata_2
);

  logic [D_SIZE-1:0] mem [REG_CNT];

  // Storage: clear on reset, otherwise single write per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_CNT; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_1 = mem[raddr_1];
  assign rdata_2 = mem[raddr_2];

endmodule

// File: rtl/write_back.sv
// Write-back stage: captures execute results or load data into the wb
// register, commits it to the register file one cycle later, and stalls the
// pipeline while a load waits for memory.
// Optional feature macro: WB_BYPASS_EN (forward the pending wb register to
// the read ports).
module write_back
  import write_back_pkg::*;
#(
  parameter int D_SIZE = 32
) (
  input  logic         clk,
  input  logic         rst,
  write_back_if.slave  bus
);

  wb_state_t         state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [D_SIZE-1:0] wb_data_q, wb_data_d;
  logic [REG_AW-1:0] pend_dest_q, pend_dest_d;
  logic              stall_c;
  logic [D_SIZE-1:0] arr_rdata_1, arr_rdata_2;

  // State, wb register and pending load destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      pend_dest_q <= '0;
    end else begin
      state_q     <= state_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      pend_dest_q <= pend_dest_d;
    end
  end

  // Next state, wb capture and stall; wb_addr/wb_data hold when no write.
  always_comb begin
    state_d     = state_q;
    wb_valid_d  = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    pend_dest_d = pend_dest_q;
    stall_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          if (!bus.ex_is_load) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = bus.ex_dest;
            wb_data_d  = bus.ex_result;
          end else if (bus.mem_rvalid) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = bus.ex_dest;
            wb_data_d  = bus.mem_rdata;
          end else begin
            pend_dest_d = bus.ex_dest;
            state_d     = LOAD_WAIT;
            stall_c     = 1'b1;
          end
        end
      end
      LOAD_WAIT: begin
        if (bus.mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = pend_dest_q;
          wb_data_d  = bus.mem_rdata;
          state_d    = IDLE;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  regfile_array #(.D_SIZE(D_SIZE)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_valid_q),
    .waddr   (wb_addr_q),
    .wdata   (wb_data_q),
    .raddr_1 (bus.raddr_1),
    .raddr_2 (bus.raddr_2),
    .rdata_1 (arr_rdata_1),
    .rdata_2 (arr_rdata_2)
  );

`ifdef WB_BYPASS_EN
  assign bus.rdata_1 = (wb_valid_q && (wb_addr_q == bus.raddr_1)) ? wb_data_q : arr_rdata_1;
  assign bus.rdata_2 = (wb_valid_q && (wb_addr_q == bus.raddr_2)) ? wb_data_q : arr_rdata_2;
`else
  assign bus.rdata_1 = arr_rdata_1;
  assign bus.rdata_2 = arr_rdata_2;
`endif

  assign bus.stall    = stall_c;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_addr  = wb_addr_q;

endmodule

// File: doc/write_back.md
# write_back

Write-back stage and architectural register file for the pipelined core. It answers the read stage's two register read requests (`raddr_1`/`raddr_2` to `rdata_1`/`rdata_2`). It also accepts results from the execute stage, waits for load data from data memory, and commits one register write per cycle. A stall output holds the upstream pipeline while a load is outstanding.

## Interface
- `D_SIZE`, default 32: register and data width.
- `clk`  in  1  pipeline clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `raddr_1`  in  3  read-port-1 register index, from the read stage.
- `raddr_2`  in  3  read-port-2 register index, from the read stage.
- `rdata_1`  out  D_SIZE  read-port-1 data, combinational.
- `rdata_2`  out  D_SIZE  read-port-2 data, combinational.
- `ex_valid`  in  1  execute stage presents an instruction that writes a register.
- `ex_is_load`  in  1  the write data comes from memory, not `ex_result`.
- `ex_dest`  in  3  destination register index.
- `ex_result`  in  D_SIZE  ALU/LOADC result.
- `mem_rvalid`  in  1  `mem_rdata` is valid this cycle.
- `mem_rdata`  in  D_SIZE  load data from data memory.
- `stall`  out  1  upstream must hold `ex_*` and its own registers.
- `wb_valid`  out  1  a write is pending in the write-back register.
- `wb_addr`  out  3  index of the pending write.

## Operation
- Storage:
  - 8 x D_SIZE register array.
  - Write-back register `{wb_valid, wb_addr, wb_data}`.
  - FSM with states IDLE and LOAD_WAIT.
- IDLE, `ex_valid=1`, `ex_is_load=0`: capture `{1, ex_dest, ex_result}` into the wb register.
- IDLE, `ex_valid=1`, `ex_is_load=1`, `mem_rvalid=1`: capture `{1, ex_dest, mem_rdata}`; stay in IDLE.
- IDLE, `ex_valid=1`, `ex_is_load=1`, `mem_rvalid=0`:
  - Latch `ex_dest` into `pend_dest`.
  - Go to LOAD_WAIT.
  - Capture `wb_valid=0`.
- LOAD_WAIT:
  - All `ex_*` inputs are ignored.
  - On `mem_rvalid=1`: capture `{1, pend_dest, mem_rdata}` and go to IDLE.
  - Otherwise capture `wb_valid=0`.
- `ex_valid=0` in IDLE: capture `wb_valid=0`.
- Every edge with `wb_valid=1`: `array[wb_addr] <= wb_data`.
- All 8 registers are writable; there is no hardwired zero.
- `stall` (combinational) = `(IDLE & ex_valid & ex_is_load & !mem_rvalid) | (LOAD_WAIT & !mem_rvalid)`.
- `mem_rvalid` seen in IDLE without a load presented is ignored.
- Read ports: `rdata_n = array[raddr_n]`, with the bypass override below when compiled in. Both ports may read the same index.
- No arithmetic; all data paths are D_SIZE wide with no extension.

## Timing
- Reset (`rst=1` at an edge), taking priority over all other inputs:
  - All array entries become 0.
  - `wb_valid=0`, `wb_addr=0`, `wb_data=0`, `pend_dest=0`.
  - FSM goes to IDLE.
- After reset: `stall=0`, and `rdata_n=0` for every index.
- Reset mid-load abandons the load. A `mem_rvalid` arriving afterwards is ignored unless a new load is presented in that cycle.
- Result latency:
  - `ex_result` presented before edge N is in the wb register after N and in the array after N+1.
  - A load completing before edge N follows the same timing.
- `stall` rises in the same cycle a missing-data load is presented. It falls in the cycle `mem_rvalid=1` arrives.
- Writing and reading the same index in one cycle: the read returns the old array value (plus bypass if enabled).

## Configuration
- `WB_BYPASS_EN` defined: if `wb_valid & (wb_addr == raddr_n)`, then `rdata_n = wb_data`. This forwards a result one cycle before it reaches the array.
- `WB_BYPASS_EN` undefined: reads return array contents only. A dependent instruction must be scheduled at least 2 cycles after the producer leaves execute.

## Structure
- The shared package holds:
  - `wb_state_t` enum {IDLE, LOAD_WAIT}.
  - `REG_CNT = 8`.
  - `REG_AW = 3`.
- Opcode defines stay in `defines.sv`; this block is opcode-agnostic.
- One sub-module, `regfile_array`: 8 x D_SIZE storage with 2 combinational read ports and 1 synchronous write port, with synchronous reset clear. The FSM, wb register and bypass mux live in the top level.

## Test plan
- ALU write, then read: `ex_dest=3`, `ex_result=0x1234`, 1 cycle.
  - With bypass: `raddr_1=3` reads 0x1234 one cycle later.
  - Without bypass: reads 0x1234 two cycles later, and the old value 0 one cycle later.
- Zero-wait load: `ex_is_load=1`, `ex_dest=5`, `mem_rvalid=1`, `mem_rdata=0xDEADBEEF` -> `stall` stays 0; `array[5]=0xDEADBEEF` after 2 edges.
- Waited load: `ex_is_load=1`, `ex_dest=2`, `mem_rvalid` arrives 3 cycles later with 0xA5A5A5A5.
  - `stall=1` for exactly 3 cycles.
  - Changing `ex_*` during the wait has no effect.
  - `array[2]=0xA5A5A5A5`.
- Back-to-back writes: dest 1, 1, 4 with values 0x11, 0x22, 0x44 -> `array[1]=0x22`, `array[4]=0x44`; `raddr_1=raddr_2=1` both return 0x22.
- Reset mid-load: `rst=1` during LOAD_WAIT, then `mem_rvalid=1` with 0xFF -> `stall=0`; all registers stay 0.
- Dual-port independence: after writing r6=0x66 and r7=0x77, `raddr_1=6`, `raddr_2=7` -> `rdata_1=0x66`, `rdata_2=0x77`.
